// File: rtl/csd_add_subb_sched.sv
// rtl/csd_add_subb_sched.sv - round-robin scheduler sharing one csd_add_subb among NREQ requesters
// One grant per cycle into a single registered result slot that is returned with the requester id.
module csd_add_subb_sched #(
  parameter int W    = 1,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_subb_a,
  input  logic [NREQ-1:0]       req_subb_b,
  input  logic [NREQ*2*W-1:0]   req_a,
  input  logic [NREQ*2*W-1:0]   req_b,
  output logic                  add_subb_a,
  output logic                  add_subb_b,
  output logic [2*W-1:0]        add_a,
  output logic [2*W-1:0]        add_b,
  input  logic [2*W-1:0]        add_s,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*W-1:0]        rsp_s,
  output logic [IDW-1:0]        rsp_id
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic           found;
  logic           grant_ok;
  logic [IDW:0]   cand;

  // The output slot can take a new result when it is free or being drained this cycle;
  // the reset pin gates the grant so nothing is offered while reset is held.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    grant_ok = arst && ((state == EMPTY) || rsp_ready);
    if (grant_ok) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = {1'b0, ptr} + (IDW+1)'(k);
        if (cand >= (IDW+1)'(NREQ)) begin
          cand = cand - (IDW+1)'(NREQ);
        end
        if (!found && req_valid[cand[IDW-1:0]]) begin
          found = 1'b1;
          win   = cand[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    add_subb_a = 1'b0;
    add_subb_b = 1'b0;
    add_a      = '0;
    add_b      = '0;
    if (found) begin
      req_ready[win] = 1'b1;
      add_subb_a     = req_subb_a[win];
      add_subb_b     = req_subb_b[win];
      add_a          = req_a[int'(win)*2*W +: 2*W];
      add_b          = req_b[int'(win)*2*W +: 2*W];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (found) state_nxt = FULL;
      FULL:    if (rsp_ready && !found) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state  <= EMPTY;
      ptr    <= IDW'(NREQ-1);
      rsp_s  <= '0;
      rsp_id <= '0;
    end else begin
      state <= state_nxt;
      if (found) begin
        ptr    <= win;
        rsp_s  <= add_s;
        rsp_id <= win;
      end
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_csd_add_subb_sched.sv
// tb/tb_csd_add_subb_sched.sv - directed self-checking bench for csd_add_subb_sched
// The shared adder is a behavioural stub: s = a + b + {subb_a, subb_b}, wrapping at 2*W bits.
module tb_csd_add_subb_sched;

  localparam int W    = 2;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                arst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_subb_a;
  logic [NREQ-1:0]     req_subb_b;
  logic [NREQ*2*W-1:0] req_a;
  logic [NREQ*2*W-1:0] req_b;
  logic                add_subb_a;
  logic                add_subb_b;
  logic [2*W-1:0]      add_a;
  logic [2*W-1:0]      add_b;
  logic [2*W-1:0]      add_s;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [2*W-1:0]      rsp_s;
  logic [IDW-1:0]      rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed stub sums: 1+2+0=3, 3+4+2=9, 5+6+1=C, 7+8+3=12->2
  logic [3:0] exp_sum [4] = '{4'h3, 4'h9, 4'hC, 4'h2};
  int         order   [6] = '{0, 1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  assign add_s = add_a + add_b + {2'b00, add_subb_a, add_subb_b};

  csd_add_subb_sched #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .arst       (arst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_subb_a (req_subb_a),
    .req_subb_b (req_subb_b),
    .req_a      (req_a),
    .req_b      (req_b),
    .add_subb_a (add_subb_a),
    .add_subb_b (add_subb_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_s      (add_s),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_s      (rsp_s),
    .rsp_id     (rsp_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst       = 1'b0;
    rsp_ready  = 1'b1;
    req_valid  = 4'b1111;
    req_subb_a = 4'b1010;
    req_subb_b = 4'b1100;
    req_a      = {4'h7, 4'h5, 4'h3, 4'h1};
    req_b      = {4'h8, 4'h6, 4'h4, 4'h2};
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_s", 32'(rsp_s), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    req_valid = 4'b0000;
    tick();
    arst = 1'b1;
    #1;
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    chk("idle_req_ready", 32'(req_ready), 0);
    chk("idle_add_a", 32'(add_a), 0);
    chk("idle_add_b", 32'(add_b), 0);

    // Single requester 2
    req_valid = 4'b0100;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'b0100);
    chk("single_add_a", 32'(add_a), 32'h5);
    chk("single_add_b", 32'(add_b), 32'h6);
    chk("single_add_subb_b", 32'(add_subb_b), 1);
    tick();
    req_valid = 4'b0000;
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_id", 32'(rsp_id), 2);
    chk("single_rsp_s", 32'(rsp_s), 32'hC);
    tick();
    chk("drain_rsp_valid", 32'(rsp_valid), 0);

    // Grant 3 alone so the round-robin sweep below starts at 0
    req_valid = 4'b1000;
    #1;
    chk("pre_req_ready", 32'(req_ready), 32'b1000);
    tick();
    chk("pre_rsp_s", 32'(rsp_s), 32'h2);

    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr%0d_req_ready", i), 32'(req_ready), 32'(1 << order[i]));
      tick();
      chk($sformatf("rr%0d_rsp_valid", i), 32'(rsp_valid), 1);
      chk($sformatf("rr%0d_rsp_id", i), 32'(rsp_id), 32'(order[i]));
      chk($sformatf("rr%0d_rsp_s", i), 32'(rsp_s), 32'(exp_sum[order[i]]));
    end

    // Output stall holding requester 1's result; its operand changes must not leak in
    rsp_ready = 1'b0;
    req_a[7:4] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_req_ready", i), 32'(req_ready), 0);
      chk($sformatf("stall%0d_add_a", i), 32'(add_a), 0);
      tick();
      chk($sformatf("stall%0d_rsp_valid", i), 32'(rsp_valid), 1);
      chk($sformatf("stall%0d_rsp_id", i), 32'(rsp_id), 1);
      chk($sformatf("stall%0d_rsp_s", i), 32'(rsp_s), 32'h9);
    end
    req_a[7:4] = 4'h3;
    rsp_ready  = 1'b1;
    #1;
    chk("refill_req_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("refill_rsp_id", 32'(rsp_id), 2);
    chk("refill_rsp_s", 32'(rsp_s), 32'hC);

    // Fairness after a gap
    req_valid = 4'b1000;
    #1;
    chk("fair_g3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0010;
    #1;
    chk("fair_g1", 32'(req_ready), 32'b0010);
    tick();
    chk("fair_g1_rsp_id", 32'(rsp_id), 1);
    req_valid = 4'b0110;
    #1;
    chk("fair_g2_first", 32'(req_ready), 32'b0100);
    tick();
    #1;
    chk("fair_g1_second", 32'(req_ready), 32'b0010);
    tick();
    chk("fair_rsp_id", 32'(rsp_id), 1);

    // Asynchronous reset while FULL
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    #2;
    arst = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_rsp_s", 32'(rsp_s), 0);
    tick();
    arst      = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1001;
    #1;
    chk("post_reset_req_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("post_reset_rsp_id", 32'(rsp_id), 0);
    chk("post_reset_rsp_s", 32'(rsp_s), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
